nrisc_firq_ctrl: RTL and testbench

- Fast-interrupt controller; produces the bank-select flag consumed by the NRISC register file (REG_Interrupt_flag) and the PC redirect/return sequence for the fetch stage.
- Synchronises and masks external IRQ lines and picks one by fixed priority.
- Saves the interrupted PC, switches to the FIRQ bank, and on return-from-interrupt restores the PC and the USR bank.
- Sits between the interrupt pins and the NRISC core top (fetch unit and register file).

---
 rtl/nrisc_firq_ctrl_pkg.sv | 21 ++
 rtl/nrisc_sync2.sv | 28 ++
 rtl/nrisc_firq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_nrisc_firq_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrisc_firq_ctrl_pkg.sv
// Shared definitions for the NRISC fast-interrupt controller.
// The FSM state encodings and the default geometry of the interrupt block live here.
package nrisc_firq_ctrl_pkg;

  // FSM states of the fast-interrupt sequencer
  typedef enum logic [1:0] {
    FIRQ_IDLE    = 2'd0,
    FIRQ_SERVICE = 2'd1,
    FIRQ_HOLD    = 2'd2
  } firq_state_e;

  localparam int          FIRQ_DEF_TAM          = 16;
  localparam int          FIRQ_DEF_N_IRQ        = 8;
  localparam logic [15:0] FIRQ_DEF_VECTOR_BASE  = 16'h0010;
  localparam int          FIRQ_DEF_VECTOR_SHIFT = 2;
  localparam int          FIRQ_DEF_HOLDOFF      = 2;

  // The hold-off counter must cover 1..15
  localparam int          FIRQ_HOLD_W           = 4;

endpackage

// File: rtl/nrisc_sync2.sv
// Two-flop synchroniser, parameterised width, asynchronous reset to zero.
// Used to bring the asynchronous IRQ lines into the clk domain.
module nrisc_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync1_r;
  logic [W-1:0] sync2_r;

  // Two-stage metastability filter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= {W{1'b0}};
      sync2_r <= {W{1'b0}};
    end else begin
      sync1_r <= d;
      sync2_r <= sync1_r;
    end
  end

  assign q = sync2_r;

endmodule

// File: rtl/nrisc_firq_ctrl.sv
// NRISC fast-interrupt controller.
// Synchronises and masks the IRQ lines, picks the lowest-index pending line,
// redirects the fetch stage to its vector and switches the register file to
// the FIRQ bank; on RETI it restores the saved PC and the USR bank, then
// blocks new entries for HOLDOFF cycles.
// Optional build macro: NRISC_FIRQ_TAILCHAIN_EN -- a return that finds a
// pending request chains straight into it without leaving the FIRQ bank.
module nrisc_firq_ctrl
  import nrisc_firq_ctrl_pkg::*;
#(
  parameter int             TAM          = FIRQ_DEF_TAM,
  parameter int             N_IRQ        = FIRQ_DEF_N_IRQ,
  parameter logic [TAM-1:0] VECTOR_BASE  = TAM'(FIRQ_DEF_VECTOR_BASE),
  parameter int             VECTOR_SHIFT = FIRQ_DEF_VECTOR_SHIFT,
  parameter int             HOLDOFF      = FIRQ_DEF_HOLDOFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] IRQ_Lines,
  input  logic             IRQ_Mask_wr,
  input  logic [N_IRQ-1:0] IRQ_Mask_D,
  input  logic [TAM-1:0]   IRQ_PC,
  input  logic             IRQ_Stall,
  input  logic             IRQ_Return,
  output logic             IRQ_Redirect,
  output logic [TAM-1:0]   IRQ_Target,
  output logic             REG_Interrupt_flag,
  output logic [N_IRQ-1:0] IRQ_Ack,
  output logic [TAM-1:0]   IRQ_Saved_PC,
  output logic [N_IRQ-1:0] IRQ_Pending
);

  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  // Index of the lowest set bit; lowest index has the highest priority
  function automatic logic [ID_W-1:0] lowest_id(input logic [N_IRQ-1:0] req);
    logic [ID_W-1:0] id;
    id = {ID_W{1'b0}};
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        id = ID_W'(i);
      end else begin
        id = id;
      end
    end
    return id;
  endfunction

  // Vector address of a line; wraps modulo 2^TAM
  function automatic logic [TAM-1:0] vector_addr(input logic [ID_W-1:0] id);
    return VECTOR_BASE + (TAM'(id) << VECTOR_SHIFT);
  endfunction

  logic [N_IRQ-1:0]       sync_s;
  logic [N_IRQ-1:0]       pending_s;
  logic [ID_W-1:0]        id_s;
  logic                   chain_s;

  logic [N_IRQ-1:0]       mask_r;
  firq_state_e            state_r,    state_s;
  logic                   redirect_r, redirect_s;
  logic [TAM-1:0]         target_r,   target_s;
  logic                   flag_r,     flag_s;
  logic [N_IRQ-1:0]       ack_r,      ack_s;
  logic [TAM-1:0]         saved_r,    saved_s;
  logic [FIRQ_HOLD_W-1:0] hold_r,     hold_s;

  nrisc_sync2 #(.W(N_IRQ)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (IRQ_Lines),
    .q   (sync_s)
  );

  assign pending_s = sync_s & mask_r;
  assign id_s      = lowest_id(pending_s);

  // Mask register: a write lands at the strobe edge and gates from the next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_r <= {N_IRQ{1'b0}};
    end else if (IRQ_Mask_wr) begin
      mask_r <= IRQ_Mask_D;
    end
  end

  // Next-state and next-output logic of the entry/service/hold sequencer
  always_comb begin
    state_s    = state_r;
    redirect_s = 1'b0;
    target_s   = target_r;
    flag_s     = flag_r;
    ack_s      = {N_IRQ{1'b0}};
    saved_s    = saved_r;
    hold_s     = hold_r;
`ifdef NRISC_FIRQ_TAILCHAIN_EN
    chain_s    = (pending_s != {N_IRQ{1'b0}});
`else
    chain_s    = 1'b0;
`endif
    case (state_r)
      FIRQ_IDLE: begin
        if ((pending_s != {N_IRQ{1'b0}}) && !IRQ_Stall) begin
          state_s     = FIRQ_SERVICE;
          redirect_s  = 1'b1;
          target_s    = vector_addr(id_s);
          flag_s      = 1'b1;
          ack_s[id_s] = 1'b1;
          saved_s     = IRQ_PC;
        end else begin
          state_s = FIRQ_IDLE;
        end
      end
      FIRQ_SERVICE: begin
        if (IRQ_Return && chain_s) begin
          // Chain into the next request without leaving the FIRQ bank
          state_s     = FIRQ_SERVICE;
          redirect_s  = 1'b1;
          target_s    = vector_addr(id_s);
          ack_s[id_s] = 1'b1;
        end else if (IRQ_Return) begin
          state_s    = FIRQ_HOLD;
          redirect_s = 1'b1;
          target_s   = saved_r;
          flag_s     = 1'b0;
          hold_s     = FIRQ_HOLD_W'(HOLDOFF);
        end else begin
          state_s = FIRQ_SERVICE;
        end
      end
      FIRQ_HOLD: begin
        if (hold_r <= {{(FIRQ_HOLD_W-1){1'b0}}, 1'b1}) begin
          state_s = FIRQ_IDLE;
          hold_s  = {FIRQ_HOLD_W{1'b0}};
        end else begin
          state_s = FIRQ_HOLD;
          hold_s  = hold_r - {{(FIRQ_HOLD_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = FIRQ_IDLE;
        flag_s  = 1'b0;
        hold_s  = {FIRQ_HOLD_W{1'b0}};
      end
    endcase
  end

  // Sequencer state and registered outputs; reset aborts any service at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= FIRQ_IDLE;
      redirect_r <= 1'b0;
      target_r   <= {TAM{1'b0}};
      flag_r     <= 1'b0;
      ack_r      <= {N_IRQ{1'b0}};
      saved_r    <= {TAM{1'b0}};
      hold_r     <= {FIRQ_HOLD_W{1'b0}};
    end else begin
      state_r    <= state_s;
      redirect_r <= redirect_s;
      target_r   <= target_s;
      flag_r     <= flag_s;
      ack_r      <= ack_s;
      saved_r    <= saved_s;
      hold_r     <= hold_s;
    end
  end

  assign IRQ_Redirect       = redirect_r;
  assign IRQ_Target         = target_r;
  assign REG_Interrupt_flag = flag_r;
  assign IRQ_Ack            = ack_r;
  assign IRQ_Saved_PC       = saved_r;
  assign IRQ_Pending        = pending_s;

endmodule

// File: tb/tb_nrisc_firq_ctrl.sv
// Self-checking bench for nrisc_firq_ctrl (TAM=16, N_IRQ=8, HOLDOFF=2).
// Table-driven entry vectors followed by hand-written multi-cycle sequences.
// Honours NRISC_FIRQ_TAILCHAIN_EN for the return-related expectations.
module tb_nrisc_firq_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  IRQ_Lines;
  logic        IRQ_Mask_wr;
  logic [7:0]  IRQ_Mask_D;
  logic [15:0] IRQ_PC;
  logic        IRQ_Stall;
  logic        IRQ_Return;
  logic        IRQ_Redirect;
  logic [15:0] IRQ_Target;
  logic        REG_Interrupt_flag;
  logic [7:0]  IRQ_Ack;
  logic [15:0] IRQ_Saved_PC;
  logic [7:0]  IRQ_Pending;

  int checks = 0;
  int errors = 0;

  nrisc_firq_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .IRQ_Lines          (IRQ_Lines),
    .IRQ_Mask_wr        (IRQ_Mask_wr),
    .IRQ_Mask_D         (IRQ_Mask_D),
    .IRQ_PC             (IRQ_PC),
    .IRQ_Stall          (IRQ_Stall),
    .IRQ_Return         (IRQ_Return),
    .IRQ_Redirect       (IRQ_Redirect),
    .IRQ_Target         (IRQ_Target),
    .REG_Interrupt_flag (REG_Interrupt_flag),
    .IRQ_Ack            (IRQ_Ack),
    .IRQ_Saved_PC       (IRQ_Saved_PC),
    .IRQ_Pending        (IRQ_Pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  mask;
    logic [7:0]  lines;
    logic [15:0] pc;
    logic [7:0]  pend;
    logic        entry;
    logic [15:0] target;
    logic [7:0]  ack;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    IRQ_Lines   = 8'h00;
    IRQ_Mask_wr = 1'b0;
    IRQ_Mask_D  = 8'h00;
    IRQ_PC      = 16'h0000;
    IRQ_Stall   = 1'b0;
    IRQ_Return  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_mask(input logic [7:0] m);
    IRQ_Mask_wr = 1'b1;
    IRQ_Mask_D  = m;
    tick();
    IRQ_Mask_wr = 1'b0;
  endtask

  // Mask 05, line 2 at PC 0123: entry on the third edge
  task automatic enter_line2();
    write_mask(8'h05);
    IRQ_Lines = 8'h04;
    IRQ_PC    = 16'h0123;
    tick();
    tick();
    tick();
  endtask

  initial begin
    vecs[0] = '{8'h05, 8'h04, 16'h0123, 8'h04, 1'b1, 16'h0018, 8'h04};
    vecs[1] = '{8'h05, 8'h07, 16'h0200, 8'h05, 1'b1, 16'h0010, 8'h01};
    vecs[2] = '{8'h00, 8'h07, 16'h0300, 8'h00, 1'b0, 16'h0000, 8'h00};
    vecs[3] = '{8'hF0, 8'hFF, 16'h0400, 8'hF0, 1'b1, 16'h0020, 8'h10};
    vecs[4] = '{8'h80, 8'h80, 16'h0500, 8'h80, 1'b1, 16'h002C, 8'h80};
    vecs[5] = '{8'hFF, 8'h00, 16'h0600, 8'h00, 1'b0, 16'h0000, 8'h00};
    vecs[6] = '{8'h0A, 8'h08, 16'hBEEF, 8'h08, 1'b1, 16'h001C, 8'h08};

    // Reset state
    do_reset();
    check("rst_redirect", {31'd0, IRQ_Redirect}, 32'd0);
    check("rst_target", {16'd0, IRQ_Target}, 32'd0);
    check("rst_flag", {31'd0, REG_Interrupt_flag}, 32'd0);
    check("rst_ack", {24'd0, IRQ_Ack}, 32'd0);
    check("rst_saved", {16'd0, IRQ_Saved_PC}, 32'd0);
    check("rst_pending", {24'd0, IRQ_Pending}, 32'd0);

    // Entry vectors: priority, masking, vector arithmetic, latency
    for (int v = 0; v < 7; v++) begin
      do_reset();
      write_mask(vecs[v].mask);
      IRQ_Lines = vecs[v].lines;
      IRQ_PC    = vecs[v].pc;
      tick();
      check("vec_edge0_redirect", {31'd0, IRQ_Redirect}, 32'd0);
      tick();
      check("vec_pending", {24'd0, IRQ_Pending}, {24'd0, vecs[v].pend});
      check("vec_edge1_redirect", {31'd0, IRQ_Redirect}, 32'd0);
      tick();
      check("vec_redirect", {31'd0, IRQ_Redirect}, {31'd0, vecs[v].entry});
      check("vec_target", {16'd0, IRQ_Target}, {16'd0, vecs[v].target});
      check("vec_ack", {24'd0, IRQ_Ack}, {24'd0, vecs[v].ack});
      check("vec_flag", {31'd0, REG_Interrupt_flag}, {31'd0, vecs[v].entry});
      if (vecs[v].entry) begin
        check("vec_saved", {16'd0, IRQ_Saved_PC}, {16'd0, vecs[v].pc});
      end else begin
        check("vec_saved_none", {16'd0, IRQ_Saved_PC}, 32'd0);
      end
      tick();
      check("vec_redirect_pulse", {31'd0, IRQ_Redirect}, 32'd0);
      check("vec_ack_pulse", {24'd0, IRQ_Ack}, 32'd0);
      check("vec_flag_hold", {31'd0, REG_Interrupt_flag}, {31'd0, vecs[v].entry});
    end

    // Return outside SERVICE is ignored
    do_reset();
    IRQ_Return = 1'b1;
    tick();
    IRQ_Return = 1'b0;
    check("idle_return_redirect", {31'd0, IRQ_Redirect}, 32'd0);
    check("idle_return_target", {16'd0, IRQ_Target}, 32'd0);

    // Return with line 2 still high
    do_reset();
    enter_line2();
    check("ret_entry_target", {16'd0, IRQ_Target}, 32'h0018);
    tick();
    IRQ_Stall  = 1'b1;
    IRQ_Return = 1'b1;
    tick();
    IRQ_Return = 1'b0;
    IRQ_Stall  = 1'b0;
    check("ret_redirect", {31'd0, IRQ_Redirect}, 32'd1);
`ifdef NRISC_FIRQ_TAILCHAIN_EN
    check("ret_chain_target", {16'd0, IRQ_Target}, 32'h0018);
    check("ret_chain_flag", {31'd0, REG_Interrupt_flag}, 32'd1);
    check("ret_chain_ack", {24'd0, IRQ_Ack}, 32'h04);
    check("ret_chain_saved", {16'd0, IRQ_Saved_PC}, 32'h0123);
`else
    check("ret_target", {16'd0, IRQ_Target}, 32'h0123);
    check("ret_flag", {31'd0, REG_Interrupt_flag}, 32'd0);
    check("ret_ack", {24'd0, IRQ_Ack}, 32'h00);
    tick();
    check("ret_hold1_redirect", {31'd0, IRQ_Redirect}, 32'd0);
    tick();
    check("ret_hold2_redirect", {31'd0, IRQ_Redirect}, 32'd0);
    check("ret_hold2_flag", {31'd0, REG_Interrupt_flag}, 32'd0);
    tick();
    check("ret_reentry_redirect", {31'd0, IRQ_Redirect}, 32'd1);
    check("ret_reentry_target", {16'd0, IRQ_Target}, 32'h0018);
    check("ret_reentry_flag", {31'd0, REG_Interrupt_flag}, 32'd1);
    check("ret_reentry_ack", {24'd0, IRQ_Ack}, 32'h04);
`endif

    // Stall holds off entry for five cycles, entry on first unstalled edge
    do_reset();
    write_mask(8'h05);
    IRQ_Stall = 1'b1;
    IRQ_Lines = 8'h04;
    tick();
    tick();
    check("stall_pending", {24'd0, IRQ_Pending}, 32'h04);
    for (int s = 0; s < 5; s++) begin
      tick();
      check("stall_no_redirect", {31'd0, IRQ_Redirect}, 32'd0);
    end
    IRQ_Stall = 1'b0;
    tick();
    check("stall_entry_redirect", {31'd0, IRQ_Redirect}, 32'd1);
    check("stall_entry_target", {16'd0, IRQ_Target}, 32'h0018);

    // Line dropped before entry cancels the request
    do_reset();
    write_mask(8'h05);
    IRQ_Stall = 1'b1;
    IRQ_Lines = 8'h04;
    tick();
    tick();
    tick();
    IRQ_Lines = 8'h00;
    tick();
    tick();
    check("cancel_pending", {24'd0, IRQ_Pending}, 32'h00);
    IRQ_Stall = 1'b0;
    tick();
    tick();
    check("cancel_redirect", {31'd0, IRQ_Redirect}, 32'd0);
    check("cancel_flag", {31'd0, REG_Interrupt_flag}, 32'd0);

    // Asynchronous reset in the middle of a service
    do_reset();
    enter_line2();
    check("areset_pre_flag", {31'd0, REG_Interrupt_flag}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("areset_flag", {31'd0, REG_Interrupt_flag}, 32'd0);
    check("areset_redirect", {31'd0, IRQ_Redirect}, 32'd0);
    check("areset_pending", {24'd0, IRQ_Pending}, 32'h00);
    check("areset_ack", {24'd0, IRQ_Ack}, 32'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick();
      check("areset_no_entry", {31'd0, IRQ_Redirect}, 32'd0);
    end
    write_mask(8'h04);
    tick();
    check("areset_rewrite_entry", {31'd0, IRQ_Redirect}, 32'd1);

    // New request pending at the return edge; line 2 dropped during service
    do_reset();
    enter_line2();
    tick();
    IRQ_Lines = 8'h01;
    IRQ_PC    = 16'h0456;
    tick();
    tick();
    check("simul_pending", {24'd0, IRQ_Pending}, 32'h01);
    check("simul_no_nest", {31'd0, IRQ_Redirect}, 32'd0);
    check("simul_flag_kept", {31'd0, REG_Interrupt_flag}, 32'd1);
    IRQ_Return = 1'b1;
    tick();
    IRQ_Return = 1'b0;
    check("simul_redirect", {31'd0, IRQ_Redirect}, 32'd1);
`ifdef NRISC_FIRQ_TAILCHAIN_EN
    check("simul_chain_target", {16'd0, IRQ_Target}, 32'h0010);
    check("simul_chain_ack", {24'd0, IRQ_Ack}, 32'h01);
    check("simul_chain_flag", {31'd0, REG_Interrupt_flag}, 32'd1);
    check("simul_chain_saved", {16'd0, IRQ_Saved_PC}, 32'h0123);
`else
    check("simul_ret_target", {16'd0, IRQ_Target}, 32'h0123);
    check("simul_ret_flag", {31'd0, REG_Interrupt_flag}, 32'd0);
    tick();
    check("simul_hold1", {31'd0, IRQ_Redirect}, 32'd0);
    tick();
    check("simul_hold2", {31'd0, IRQ_Redirect}, 32'd0);
    tick();
    check("simul_new_redirect", {31'd0, IRQ_Redirect}, 32'd1);
    check("simul_new_target", {16'd0, IRQ_Target}, 32'h0010);
    check("simul_new_ack", {24'd0, IRQ_Ack}, 32'h01);
    check("simul_new_saved", {16'd0, IRQ_Saved_PC}, 32'h0456);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
